// File: rtl/cc_input_pkg.sv
// -----------------------------------------------------------------------------
// cc_input_pkg
// Shared definitions for the Crazy Climber player-input front end:
//   - PS/2 scan codes for the mapped keys
//   - bit positions inside the HPS joystick words
//   - key-state vector indices and the scan-code -> key decoder
//   - the coin sequencer state encoding
//   - the opposing-direction (SOCD) cancel helper used when CC_INPUT_SOCD_EN
//     is defined in cc_input_ctrl
// -----------------------------------------------------------------------------
package cc_input_pkg;

  // Stick keys are matched on the low 8 bits only, so the E0-prefixed arrow
  // codes sent by real keyboards decode the same as the bare codes.
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  // Start and coin keys must match the full 9-bit code, E0 prefix included.
  localparam logic [8:0] SC_F1    = 9'h005;
  localparam logic [8:0] SC_1     = 9'h016;
  localparam logic [8:0] SC_F2    = 9'h006;
  localparam logic [8:0] SC_2     = 9'h01E;
  localparam logic [8:0] SC_COIN5 = 9'h02E;
  localparam logic [8:0] SC_COIN6 = 9'h036;

  // Joystick word bit positions (same layout on both joysticks).
  localparam int JOY_R      = 0;
  localparam int JOY_L      = 1;
  localparam int JOY_D      = 2;
  localparam int JOY_U      = 3;
  localparam int JOY_RR     = 4;
  localparam int JOY_RL     = 5;
  localparam int JOY_RD     = 6;
  localparam int JOY_RU     = 7;
  localparam int JOY_START1 = 8;
  localparam int JOY_START2 = 9;
  localparam int JOY_W      = 10;  // number of joystick bits actually used

  // Indices into the key-state vector.
  localparam int K_UP     = 0;
  localparam int K_DOWN   = 1;
  localparam int K_LEFT   = 2;
  localparam int K_RIGHT  = 3;
  localparam int K_W      = 4;
  localparam int K_S      = 5;
  localparam int K_A      = 6;
  localparam int K_D      = 7;
  localparam int K_F1     = 8;
  localparam int K_1      = 9;
  localparam int K_F2     = 10;
  localparam int K_2      = 11;
  localparam int K_5      = 12;
  localparam int K_6      = 13;
  localparam int NUM_KEYS = 14;

  // Pending coin credits saturate here; further requests are dropped.
  localparam logic [1:0] PENDING_MAX = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

  // Packed so that {up, down, left, right} maps straight onto a 4-bit port.
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } stick_t;

  // One-hot mask of the key(s) a 9-bit scan code refers to; all zero when
  // the code is not mapped.
  function automatic logic [NUM_KEYS-1:0] key_mask(input logic [8:0] code);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    case (code[7:0])
      SC_UP:    m[K_UP]    = 1'b1;
      SC_DOWN:  m[K_DOWN]  = 1'b1;
      SC_LEFT:  m[K_LEFT]  = 1'b1;
      SC_RIGHT: m[K_RIGHT] = 1'b1;
      SC_W:     m[K_W]     = 1'b1;
      SC_S:     m[K_S]     = 1'b1;
      SC_A:     m[K_A]     = 1'b1;
      SC_D:     m[K_D]     = 1'b1;
      default:  ;
    endcase
    case (code)
      SC_F1:    m[K_F1] = 1'b1;
      SC_1:     m[K_1]  = 1'b1;
      SC_F2:    m[K_F2] = 1'b1;
      SC_2:     m[K_2]  = 1'b1;
      SC_COIN5: m[K_5]  = 1'b1;
      SC_COIN6: m[K_6]  = 1'b1;
      default:  ;
    endcase
    return m;
  endfunction

  // Opposing directions held together cancel to neither.
  function automatic stick_t socd_filter(input stick_t s);
    stick_t o;
    o = s;
    if (s.up && s.down) begin
      o.up   = 1'b0;
      o.down = 1'b0;
    end
    if (s.left && s.right) begin
      o.left  = 1'b0;
      o.right = 1'b0;
    end
    return o;
  endfunction

endpackage

// File: rtl/cc_coin_seq.sv
// -----------------------------------------------------------------------------
// cc_coin_seq
// Queues coin requests (up to 3 pending) and replays each one as a coin pulse
// exactly COIN_PULSE_CYCLES wide, followed by at least COIN_GAP_CYCLES+1 low
// cycles (the gap plus one IDLE pass) before the next credit.
//
// Parameters:
//   COIN_PULSE_CYCLES - cycles coin is held high per credit (>= 1)
//   COIN_GAP_CYCLES   - cycles spent in GAP after each pulse   (>= 1)
// Ports:
//   clk_sys - clock, rising edge
//   reset_n - asynchronous active-low reset
//   req     - single-cycle coin request
//   coin    - registered coin pulse output
// -----------------------------------------------------------------------------
module cc_coin_seq
  import cc_input_pkg::*;
#(
  parameter int unsigned COIN_PULSE_CYCLES = 1200000,
  parameter int unsigned COIN_GAP_CYCLES   = 1200000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  output logic coin
);

  localparam logic [31:0] PULSE_LOAD = 32'(COIN_PULSE_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD   = 32'(COIN_GAP_CYCLES - 1);

  coin_state_t state;
  logic [31:0] timer;
  logic [1:0]  pending;
  logic        consume;

  // A credit leaves the queue on the same edge the FSM leaves IDLE.
  assign consume = (state == IDLE) && (pending != 2'd0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the statements appear in.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 2'd0;
    end else begin
      // A request and a consume on the same edge cancel out.
      case ({req, consume})
        2'b10:   if (pending != PENDING_MAX) pending <= pending + 2'd1;
        2'b01:   pending <= pending - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
      coin  <= 1'b0;
    end else begin
      // Output follows the state one cycle later, so its high time equals
      // the number of cycles spent in PULSE.
      coin <= (state == PULSE);
      case (state)
        IDLE: begin
          if (consume) begin
            state <= PULSE;
            timer <= PULSE_LOAD;
          end
        end
        PULSE: begin
          if (timer == '0) begin
            state <= GAP;
            timer <= GAP_LOAD;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        GAP: begin
          if (timer == '0) state <= IDLE;
          else             timer <= timer - 32'd1;
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cc_input_ctrl.sv
// -----------------------------------------------------------------------------
// cc_input_ctrl
// Player-input front end for the Crazy Climber core. Decodes toggle-coded
// PS/2 key events into key states, merges them with both joysticks and drives
// registered twin-stick, start and metered coin outputs.
//
// Build option:
//   CC_INPUT_SOCD_EN - when defined, opposing directions on a stick cancel
//                      (up+down -> neither, left+right -> neither).
//
// Parameters:
//   COIN_PULSE_CYCLES - coin1 high time per credit, in clk_sys cycles
//   COIN_GAP_CYCLES   - minimum coin1 low time between credits (plus one)
// Ports:
//   clk_sys    - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   ps2_key    - [10] event toggle, [9] pressed, [8] E0 prefix, [7:0] code
//   joystick_0 - joystick word, player 1
//   joystick_1 - joystick word, player 2 (same layout)
//   l_stick    - left stick {up, down, left, right}
//   r_stick    - right stick {up, down, left, right}
//   start1     - player 1 start
//   start2     - player 2 start
//   coin1      - metered coin pulse
// -----------------------------------------------------------------------------
module cc_input_ctrl
  import cc_input_pkg::*;
#(
  parameter int unsigned COIN_PULSE_CYCLES = 1200000,
  parameter int unsigned COIN_GAP_CYCLES   = 1200000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic [3:0]  l_stick,
  output logic [3:0]  r_stick,
  output logic        start1,
  output logic        start2,
  output logic        coin1
);

  // ---------------------------------------------------------------------------
  // Stage 1: key event decode and joystick capture
  // ---------------------------------------------------------------------------
  logic                primed;
  logic                toggle_copy;
  logic [NUM_KEYS-1:0] keys;
  logic [NUM_KEYS-1:0] mask;
  logic [JOY_W-1:0]    joy;
  logic                key_event;

  // The first edge after reset only learns the current toggle level; the
  // word sitting on ps2_key at that point is stale and must not be decoded.
  assign key_event = primed && (ps2_key[10] != toggle_copy);
  assign mask      = key_mask(ps2_key[8:0]);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      primed      <= 1'b0;
      toggle_copy <= 1'b0;
      keys        <= '0;
      joy         <= '0;
    end else begin
      primed      <= 1'b1;
      toggle_copy <= ps2_key[10];
      joy         <= joystick_0[JOY_W-1:0] | joystick_1[JOY_W-1:0];
      if (key_event) begin
        keys <= ps2_key[9] ? (keys | mask) : (keys & ~mask);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Merge (combinational, between the two register stages)
  // ---------------------------------------------------------------------------
  stick_t l_raw;
  stick_t r_raw;
  stick_t l_next;
  stick_t r_next;
  logic   start1_next;
  logic   start2_next;
  logic   coin_src;

  // NOTE: every output of this block is assigned on every pass, so no latch
  // is inferred; keep it that way when adding terms.
  always_comb begin
    l_raw.up    = keys[K_W]     | joy[JOY_U];
    l_raw.down  = keys[K_S]     | joy[JOY_D];
    l_raw.left  = keys[K_A]     | joy[JOY_L];
    l_raw.right = keys[K_D]     | joy[JOY_R];
    r_raw.up    = keys[K_UP]    | joy[JOY_RU];
    r_raw.down  = keys[K_DOWN]  | joy[JOY_RD];
    r_raw.left  = keys[K_LEFT]  | joy[JOY_RL];
    r_raw.right = keys[K_RIGHT] | joy[JOY_RR];
    start1_next = keys[K_F1] | keys[K_1] | joy[JOY_START1];
    start2_next = keys[K_F2] | keys[K_2] | joy[JOY_START2];
    coin_src    = start1_next | start2_next | keys[K_5] | keys[K_6];
  end

`ifdef CC_INPUT_SOCD_EN
  assign l_next = socd_filter(l_raw);
  assign r_next = socd_filter(r_raw);
`else
  assign l_next = l_raw;
  assign r_next = r_raw;
`endif

  // ---------------------------------------------------------------------------
  // Stage 2: output registers and coin request edge detect
  // ---------------------------------------------------------------------------
  logic coin_src_q;
  logic coin_req;

  // Rising edge of the unregistered merge, so a request is captured on the
  // same edge the start/stick outputs update.
  assign coin_req = coin_src & ~coin_src_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      l_stick    <= '0;
      r_stick    <= '0;
      start1     <= 1'b0;
      start2     <= 1'b0;
      coin_src_q <= 1'b0;
    end else begin
      l_stick    <= l_next;
      r_stick    <= r_next;
      start1     <= start1_next;
      start2     <= start2_next;
      coin_src_q <= coin_src;
    end
  end

  cc_coin_seq #(
    .COIN_PULSE_CYCLES (COIN_PULSE_CYCLES),
    .COIN_GAP_CYCLES   (COIN_GAP_CYCLES)
  ) u_coin_seq (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .req     (coin_req),
    .coin    (coin1)
  );

endmodule

// File: tb/tb_cc_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cc_input_ctrl
// Directed bench for cc_input_ctrl with COIN_PULSE_CYCLES=8, COIN_GAP_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cc_input_ctrl;

  localparam int PULSE = 8;
  localparam int GAP   = 4;

  logic        clk_sys;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic [3:0]  l_stick;
  logic [3:0]  r_stick;
  logic        start1;
  logic        start2;
  logic        coin1;

  int compared;
  int mismatched;

  cc_input_ctrl #(
    .COIN_PULSE_CYCLES (PULSE),
    .COIN_GAP_CYCLES   (GAP)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .l_stick    (l_stick),
    .r_stick    (r_stick),
    .start1     (start1),
    .start2     (start2),
    .coin1      (coin1)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One key event per call: flip the toggle bit, then advance one cycle.
  task automatic key(input logic [8:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, code};
    @(negedge clk_sys);
  endtask

  // Count consecutive falling-edge samples at the given level, up to limit.
  task automatic count_level(input logic level, input int limit, output int n);
    n = 0;
    while (coin1 === level && n < limit) begin
      n++;
      @(negedge clk_sys);
    end
  endtask

  initial begin
    int n;
    compared   = 0;
    mismatched = 0;

    // Toggle bit high and an "up arrow pressed" word already present: a
    // tracker that decoded the first edge would light r_stick.
    reset_n    = 1'b0;
    ps2_key    = {1'b1, 1'b1, 9'h075};
    joystick_0 = '0;
    joystick_1 = '0;
    repeat (3) @(negedge clk_sys);
    check("in_reset_outputs", {l_stick, r_stick, start1, start2, coin1}, 11'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    check("after_reset_outputs", {l_stick, r_stick, start1, start2, coin1}, 11'h0);

    // Up arrow press: two-edge latency.
    key(9'h075, 1'b1);
    check("up_latency_1edge", r_stick, 4'b0000);
    @(negedge clk_sys);
    check("up_pressed", r_stick, 4'b1000);
    key(9'h075, 1'b0);
    @(negedge clk_sys);
    check("up_released", r_stick, 4'b0000);

    // E0-prefixed left arrow decodes on the low byte.
    key(9'h16B, 1'b1);
    @(negedge clk_sys);
    check("e0_left_pressed", r_stick, 4'b0010);
    key(9'h16B, 1'b0);

    // W key drives left stick up.
    key(9'h01D, 1'b1);
    @(negedge clk_sys);
    check("w_pressed", {l_stick, r_stick}, 8'b1000_0000);
    key(9'h01D, 1'b0);
    @(negedge clk_sys);
    check("w_released", l_stick, 4'b0000);

    // E0+05 is not F1: start and coin keys need the exact 9-bit code.
    key(9'h105, 1'b1);
    @(negedge clk_sys);
    check("e0_f1_ignored", {start1, start2}, 2'b00);
    key(9'h105, 1'b0);
    repeat (4) @(negedge clk_sys);
    check("e0_f1_no_coin", coin1, 1'b0);

    // Key "1" gives start1 (and a coin credit that is allowed to drain).
    key(9'h016, 1'b1);
    @(negedge clk_sys);
    check("key1_start1", {start1, start2}, 2'b10);
    key(9'h016, 1'b0);
    @(negedge clk_sys);
    check("key1_release", start1, 1'b0);
    repeat (30) @(negedge clk_sys);

    // joystick_1 Start2 pulsed for one cycle.
    joystick_1 = 16'h0200;
    @(negedge clk_sys);
    joystick_1 = 16'h0000;
    check("start2_latency", start2, 1'b0);
    @(negedge clk_sys);
    check("start2_high", start2, 1'b1);
    @(negedge clk_sys);
    check("start2_one_cycle", {start2, coin1}, 2'b00);
    @(negedge clk_sys);
    check("coin_latency", coin1, 1'b1);
    count_level(1'b1, 100, n);
    check("coin_width_start2", n, PULSE);
    repeat (10) @(negedge clk_sys);

    // Five coin-key presses two cycles apart: one in flight, three queued,
    // the fifth dropped by saturation.
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          key((i % 2 == 0) ? 9'h02E : 9'h036, 1'b1);
          key((i % 2 == 0) ? 9'h02E : 9'h036, 1'b0);
        end
      end
      begin
        for (int p = 0; p < 4; p++) begin
          count_level(1'b0, 60, n);
          check($sformatf("burst_rise_%0d", p), coin1, 1'b1);
          count_level(1'b1, 100, n);
          check($sformatf("burst_width_%0d", p), n, PULSE);
          if (p < 3) begin
            count_level(1'b0, 100, n);
            check($sformatf("burst_gap_%0d", p), n, GAP + 1);
          end
        end
        count_level(1'b0, 40, n);
        check("burst_no_fifth", n, 40);
      end
    join

    // Three presses: reset on the 3rd high cycle of the first pulse, with
    // two credits pending at that moment.
    fork
      begin
        key(9'h02E, 1'b1);
        key(9'h02E, 1'b0);
        key(9'h036, 1'b1);
        key(9'h036, 1'b0);
        key(9'h02E, 1'b1);
        key(9'h02E, 1'b0);
      end
      begin
        count_level(1'b0, 60, n);
        check("rst_pulse_rise", coin1, 1'b1);
        repeat (2) @(negedge clk_sys);
        check("rst_third_high", coin1, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rst_coin_drop", coin1, 1'b0);
      end
    join
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    count_level(1'b0, 60, n);
    check("rst_pending_cleared", n, 60);

    // Opposing directions: joystick up+down plus key A.
    joystick_0 = 16'h000C;
    key(9'h01C, 1'b1);
    @(negedge clk_sys);
`ifdef CC_INPUT_SOCD_EN
    check("socd_l_stick", l_stick, 4'b0010);
`else
    check("socd_l_stick", l_stick, 4'b1110);
`endif
    joystick_0 = 16'h0030;
    key(9'h01C, 1'b0);
    @(negedge clk_sys);
`ifdef CC_INPUT_SOCD_EN
    check("socd_r_stick", {l_stick, r_stick}, 8'b0000_0000);
`else
    check("socd_r_stick", {l_stick, r_stick}, 8'b0000_0011);
`endif
    joystick_0 = 16'h0000;
    repeat (2) @(negedge clk_sys);
    check("final_idle", {l_stick, r_stick, start1, start2, coin1}, 11'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
